problema1_button_ctrl: RTL and testbench

//   Avalon-MM slave controller for the active-low push-buttons of problema1.

---
 rtl/problema1_button_pkg.sv | 16 +
 rtl/problema1_button_ctrl_if.sv | 26 ++
 rtl/problema1_button_ctrl_debounce.sv | 60 ++++++
 rtl/problema1_button_ctrl.sv | 92 +++++++++
 tb/tb_problema1_button_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/problema1_button_pkg.sv
// Shared constants for the problema1 push-button controller: register
// addresses, bus widths and the idle level of an active-low button line.
package problema1_button_pkg;

    localparam int AV_ADDR_W = 2;
    localparam int AV_DATA_W = 32;

    localparam logic [AV_ADDR_W-1:0] ADDR_DATA = 2'd0;
    localparam logic [AV_ADDR_W-1:0] ADDR_RSVD = 2'd1;
    localparam logic [AV_ADDR_W-1:0] ADDR_MASK = 2'd2;
    localparam logic [AV_ADDR_W-1:0] ADDR_EDGE = 2'd3;

    // Buttons pull the line low when pressed, so "released" is a 1.
    localparam logic BTN_RELEASED = 1'b1;

endpackage

// File: rtl/problema1_button_ctrl_if.sv
// Avalon-MM slave bus bundle for the button controller.
interface problema1_button_ctrl_if;
    import problema1_button_pkg::*;

    logic [AV_ADDR_W-1:0] address;
    logic                 chipselect;
    logic                 write_n;
    logic [AV_DATA_W-1:0] writedata;
    logic [AV_DATA_W-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/problema1_button_ctrl_debounce.sv
// One button line: 2-FF synchroniser, stability counter and accepted level.
// The fall output pulses for one cycle, registered alongside the state update,
// whenever a press (1->0) is accepted.
module button_debounce
    import problema1_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic state,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             state_reg;
    logic             fall_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= BTN_RELEASED;
            sync2_reg <= BTN_RELEASED;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles;
    // the counter restarts at the accept point so it can never wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg   <= '0;
            state_reg <= BTN_RELEASED;
            fall_reg  <= 1'b0;
        end else begin
            fall_reg <= 1'b0;
            if (sync2_reg == state_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                state_reg <= sync2_reg;
                cnt_reg   <= '0;
                fall_reg  <= ~sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign state = state_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/problema1_button_ctrl.sv
// Avalon-MM button controller: debounced levels, sticky press flags with
// write-1-to-clear, and a maskable level interrupt.
module problema1_button_ctrl
    import problema1_button_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    problema1_button_ctrl_if.slave bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);

    logic [WIDTH-1:0]     btn_state;
    logic [WIDTH-1:0]     btn_fall;
    logic [WIDTH-1:0]     irq_mask_reg;
    logic [WIDTH-1:0]     irq_mask_next;
    logic [WIDTH-1:0]     edge_capture_reg;
    logic [WIDTH-1:0]     edge_capture_next;
    logic [AV_DATA_W-1:0] readdata_reg;
    logic [AV_DATA_W-1:0] readdata_next;
    logic                 irq_reg;
    logic                 wr_en;

    // Register bits above WIDTH carry no state.
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata[AV_DATA_W-1:WIDTH];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_debounce (
                .clk    (clk),
                .reset_n(reset_n),
                .raw    (in_port[gi]),
                .state  (btn_state[gi]),
                .fall   (btn_fall[gi])
            );
        end
    endgenerate

    assign wr_en = bus.chipselect & ~bus.write_n;

    // Next MASK/EDGE values; a press arriving with a clear of the same bit keeps it set.
    always_comb begin
        irq_mask_next     = irq_mask_reg;
        edge_capture_next = edge_capture_reg;
        if (wr_en && bus.address == ADDR_MASK) begin
            irq_mask_next = bus.writedata[WIDTH-1:0];
        end
        if (wr_en && bus.address == ADDR_EDGE) begin
            edge_capture_next = edge_capture_reg & ~bus.writedata[WIDTH-1:0];
        end
        edge_capture_next = edge_capture_next | btn_fall;
    end

    // Read mux, sampled every cycle regardless of chipselect.
    always_comb begin
        readdata_next = '0;
        case (bus.address)
            ADDR_DATA: readdata_next[WIDTH-1:0] = ~btn_state;
            ADDR_MASK: readdata_next[WIDTH-1:0] = irq_mask_reg;
            ADDR_EDGE: readdata_next[WIDTH-1:0] = edge_capture_reg;
            default:   readdata_next = '0;
        endcase
    end

    // Control/status registers, registered read data and interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_reg     <= '0;
            edge_capture_reg <= '0;
            readdata_reg     <= '0;
            irq_reg          <= 1'b0;
        end else begin
            irq_mask_reg     <= irq_mask_next;
            edge_capture_reg <= edge_capture_next;
            readdata_reg     <= readdata_next;
            irq_reg          <= |(edge_capture_reg & irq_mask_reg);
        end
    end

    assign bus.readdata = readdata_reg;
    assign irq          = irq_reg;

endmodule

// File: tb/tb_problema1_button_ctrl.sv
// Self-checking bench for problema1_button_ctrl with DEBOUNCE_CYCLES=4.
module tb_problema1_button_ctrl;
    import problema1_button_pkg::*;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] in_port = 2'b11;
    logic       irq;

    problema1_button_ctrl_if bus();

    problema1_button_ctrl #(
        .WIDTH          (2),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .in_port(in_port),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [1:0] raw_q[$];     // pin value seen before each clock edge since reset
    int         n_edges;
    logic [1:0] st_m;         // accepted level (1 = released)
    logic [1:0] fall_pend;    // press accepted on the previous edge
    logic [1:0] edge_m;
    logic [1:0] mask_m;
    logic       irq_m;
    logic [31:0] rd_m;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Synchronised level after edge n: pin value from two edges back, idle before that.
    function automatic logic sync_at(int n, int b);
        if (n < 2) return 1'b1;
        return raw_q[n-2][b];
    endfunction

    task automatic model_reset();
        raw_q.delete();
        n_edges   = 0;
        st_m      = 2'b11;
        fall_pend = 2'b00;
        edge_m    = 2'b00;
        mask_m    = 2'b00;
        irq_m     = 1'b0;
        rd_m      = 32'h0;
    endtask

    // One clock: capture the pre-edge inputs, advance the model, compare outputs.
    task automatic tick();
        logic [1:0]  raw_pre;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        wr;
        logic [1:0]  st_new;
        logic [1:0]  fall_new;
        logic [1:0]  clr;
        bit          flip;
        raw_pre = in_port;
        addr    = bus.address;
        wdata   = bus.writedata;
        wr      = bus.chipselect && !bus.write_n;
        @(posedge clk);
        #1;
        if (!reset_n) return;
        n_edges++;
        raw_q.push_back(raw_pre);
        case (addr)
            ADDR_DATA: rd_m = {30'b0, ~st_m};
            ADDR_MASK: rd_m = {30'b0, mask_m};
            ADDR_EDGE: rd_m = {30'b0, edge_m};
            default:   rd_m = 32'h0;
        endcase
        irq_m = |(edge_m & mask_m);
        clr = (wr && addr == ADDR_EDGE) ? wdata[1:0] : 2'b00;
        if (wr && addr == ADDR_MASK) mask_m = wdata[1:0];
        st_new   = st_m;
        fall_new = 2'b00;
        for (int b = 0; b < 2; b++) begin
            // A level is accepted once the synced line has disagreed for DEB cycles in a row.
            flip = 1'b1;
            for (int j = 1; j <= DEB; j++) begin
                if (sync_at(n_edges - j, b) == st_m[b]) flip = 1'b0;
            end
            if (flip) begin
                st_new[b] = ~st_m[b];
                if (st_m[b]) fall_new[b] = 1'b1;
            end
        end
        edge_m    = (edge_m & ~clr) | fall_pend;
        fall_pend = fall_new;
        st_m      = st_new;
        check_val("rd", bus.readdata, rd_m);
        check_val("irq", {31'b0, irq}, {31'b0, irq_m});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_val("rst_rd", bus.readdata, 32'h0);
        check_val("rst_irq", {31'b0, irq}, 32'h0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        bus.address    = ADDR_DATA;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        model_reset();
        #2;
        do_reset();

        // Clean press of bit0: DATA visible 2 sync + 4 debounce + 1 read cycles later
        in_port     = 2'b10;
        bus.address = ADDR_DATA;
        ticks(6);
        check_val("press_lat_early", bus.readdata, 32'h0);
        tick();
        check_val("press_lat", bus.readdata, 32'h1);
        ticks(13);
        bus.address = ADDR_EDGE;
        tick();
        check_val("press_edge", bus.readdata, 32'h1);

        // Bouncing bit1 never gets accepted
        for (int i = 0; i < 8; i++) begin
            in_port = {i[0], 1'b0};
            ticks(2);
        end
        in_port = 2'b10;
        ticks(10);
        bus.address = ADDR_DATA;
        tick();
        check_val("bounce_data", bus.readdata, 32'h1);
        bus.address = ADDR_EDGE;
        tick();
        check_val("bounce_edge", bus.readdata, 32'h1);

        // Interrupt raise, W1C clear, and masked press
        bus_write(ADDR_EDGE, 32'h3);
        bus_write(ADDR_MASK, 32'h3);
        in_port     = 2'b00;
        bus.address = ADDR_EDGE;
        ticks(10);
        check_val("irq_edge", bus.readdata, 32'h2);
        check_val("irq_on", {31'b0, irq}, 32'h1);
        bus_write(ADDR_EDGE, 32'h2);
        tick();
        check_val("irq_clr", {31'b0, irq}, 32'h0);
        check_val("irq_clr_edge", bus.readdata, 32'h0);
        bus_write(ADDR_MASK, 32'h0);
        in_port = 2'b10;
        ticks(10);
        in_port     = 2'b00;
        bus.address = ADDR_EDGE;
        ticks(10);
        check_val("nomask_edge", bus.readdata, 32'h2);
        check_val("nomask_irq", {31'b0, irq}, 32'h0);

        // Press edge and W1C of the same bit on the same clock: set wins
        bus_write(ADDR_EDGE, 32'h3);
        in_port = 2'b11;
        ticks(10);
        in_port = 2'b10;
        ticks(6);
        bus_write(ADDR_EDGE, 32'h1);
        tick();
        check_val("collision", bus.readdata, 32'h1);

        // Release only: no capture
        bus_write(ADDR_EDGE, 32'h3);
        in_port = 2'b11;
        ticks(10);
        bus.address = ADDR_EDGE;
        tick();
        check_val("release_edge", bus.readdata, 32'h0);
        bus.address = ADDR_DATA;
        tick();
        check_val("release_data", bus.readdata, 32'h0);

        // Randomised traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) in_port = 2'($urandom_range(0, 3));
            bus.address    = 2'($urandom_range(0, 3));
            bus.chipselect = 1'($urandom_range(0, 1));
            bus.write_n    = ($urandom_range(0, 3) != 0);
            bus.writedata  = $urandom;
            tick();
        end
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;

        // Reset mid-debounce discards the count
        in_port = 2'b10;
        ticks(3);
        do_reset();
        bus.address = ADDR_EDGE;
        tick();
        check_val("rst_edge", bus.readdata, 32'h0);
        bus.address = ADDR_DATA;
        tick();
        check_val("rst_data", bus.readdata, 32'h0);
        ticks(10);
        check_val("post_rst_press", bus.readdata, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
